// File: rtl/linebuf_pkg.sv
// Shared types and sizes for the 9x9 line-buffer window generator.
package linebuf_pkg;

   localparam int PIX_W  = 7;
   localparam int WIN    = 9;
   localparam int NFIELD = WIN * WIN;
   localparam int CW     = 5;

   typedef logic [PIX_W-1:0] pix_t;
   typedef logic [CW-1:0]    coord_t;

endpackage

// File: rtl/linebuf_window9_if.sv
// Pixel stream in, packed window plus coordinates out.
interface linebuf_window9_if;
   import linebuf_pkg::*;

   logic                      pix_valid;
   pix_t                      pix_in;
   logic                      sof;
   logic                      win_valid;
   logic [NFIELD*PIX_W-1:0]   win_data;
   coord_t                    win_x;
   coord_t                    win_y;
   logic                      frame_done;

   modport master (
      output pix_valid, pix_in, sof,
      input  win_valid, win_data, win_x, win_y, frame_done
   );

   modport slave (
      input  pix_valid, pix_in, sof,
      output win_valid, win_data, win_x, win_y, frame_done
   );

endinterface

// File: rtl/linebuf_row.sv
// One image-row delay line: q is the value written DEPTH enables ago.
module linebuf_row #(
   parameter int DEPTH = 28,
   parameter int W     = 7
) (
   input  logic         clk,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [DEPTH-1:0][W-1:0] sr;

   // Storage is deliberately unreset; stale rows are masked by the y>=8 gate.
   always_ff @(posedge clk) begin
      if (en) sr <= {sr[DEPTH-2:0], d};
   end

   assign q = sr[DEPTH-1];

endmodule

// File: rtl/linebuf_window9.sv
// Raster stream to 9x9 sliding window; one registered window per pixel with a full neighbourhood.
module linebuf_window9 #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int PIX_W = linebuf_pkg::PIX_W,
   parameter int WIN   = linebuf_pkg::WIN
) (
   input  logic               clk,
   input  logic               rst_n,
   linebuf_window9_if.slave   bus
);
   import linebuf_pkg::*;

   localparam int     NL   = WIN - 1;
   localparam coord_t XMAX = coord_t'(IMG_W - 1);
   localparam coord_t YMAX = coord_t'(IMG_H - 1);
   localparam coord_t EDGE = coord_t'(WIN - 1);

   typedef logic [PIX_W-1:0] px_t;

   coord_t x_q, y_q, cx, cy, x_nxt, y_nxt;
   logic   acc, last, in_win;
   px_t    tap [NL+1];
   px_t [WIN-1:0][WIN-1:0]      win_q, win_nxt;
   logic [WIN*WIN*PIX_W-1:0]    win_flat;

   assign acc    = bus.pix_valid;
   assign tap[0] = bus.pix_in;

   // tap[i] is row y-i at the current column; each line feeds the next.
   generate
      for (genvar i = 0; i < NL; i++) begin : g_row
         linebuf_row #(.DEPTH(IMG_W), .W(PIX_W)) u_row (
            .clk (clk),
            .en  (acc),
            .d   (tap[i]),
            .q   (tap[i+1])
         );
      end
   endgenerate

   // sof overrides the counters, so the pixel it marks is always (0,0).
   always_comb begin
      cx     = bus.sof ? '0 : x_q;
      cy     = bus.sof ? '0 : y_q;
      last   = (cx == XMAX) && (cy == YMAX) && !bus.sof;
      in_win = (cx >= EDGE) && (cy >= EDGE);
      x_nxt  = cx + coord_t'(1);
      y_nxt  = cy;
      if (cx == XMAX) begin
         x_nxt = '0;
         y_nxt = (cy == YMAX) ? '0 : cy + coord_t'(1);
      end
   end

   // Shift left one column; new right column is oldest row on top, pix_in at bottom.
   always_comb begin
      win_nxt = win_q;
      for (int r = 0; r < WIN; r++) begin
         for (int c = 0; c < WIN-1; c++) win_nxt[r][c] = win_q[r][c+1];
         win_nxt[r][WIN-1] = tap[WIN-1-r];
      end
   end

   always_comb begin
      win_flat = '0;
      for (int r = 0; r < WIN; r++)
         for (int c = 0; c < WIN; c++)
            win_flat[(r*WIN+c)*PIX_W +: PIX_W] = win_nxt[r][c];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q            <= '0;
         y_q            <= '0;
         win_q          <= '0;
         bus.win_valid  <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.win_data   <= '0;
         bus.win_x      <= '0;
         bus.win_y      <= '0;
      end else begin
         bus.win_valid  <= acc && in_win;
         bus.frame_done <= acc && last;
         if (acc) begin
            x_q   <= x_nxt;
            y_q   <= y_nxt;
            win_q <= win_nxt;
            if (in_win) begin
               bus.win_data <= win_flat;
               bus.win_x    <= cx;
               bus.win_y    <= cy;
            end
         end
      end
   end

endmodule
